// File: rtl/config_loader.sv
// config_loader: streams configuration words into a level-sensitive latch array.
// Each accepted word is presented on io_d_out for a setup cycle, strobed into
// its latch with a single one-hot enable, then held for one more cycle so the
// latch closes on stable data. All outputs decode from registered state only.
module config_loader #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 20,
  parameter int IDX_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_abort,
  input  logic                 io_word_valid,
  input  logic [WORD_W-1:0]    io_word_data,
  output logic                 io_word_ready,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t              state, state_next;
  logic [IDX_W-1:0]    idx, idx_next;
  logic [WORD_W-1:0]   data_q, data_next;

  // One-hot latch enable for the word currently being strobed.
  function automatic logic [NUM_WORDS-1:0] enable_decode(input logic [IDX_W-1:0] i);
    enable_decode = NUM_WORDS'(1) << i;
  endfunction

  // State, word index and latch data register; reset clears all of them so the
  // array bus returns to zero immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      data_q <= '0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      data_q <= data_next;
    end
  end

  // Sequencing and output decode. Abort overrides every non-idle transition and
  // blocks a word capture in the same cycle; in IDLE a start wins over abort.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    data_next     = data_q;
    io_word_ready = 1'b0;
    io_configs_en = '0;
    io_busy       = (state != S_IDLE);
    io_done       = 1'b0;

    case (state)
      S_IDLE: begin
        if (io_start) begin
          state_next = S_WAIT;
          idx_next   = '0;
        end
      end
      S_WAIT: begin
        io_word_ready = 1'b1;
        if (io_word_valid) begin
          data_next  = io_word_data;
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        state_next = S_STROBE;
      end
      S_STROBE: begin
        io_configs_en = enable_decode(idx);
        state_next    = S_HOLD;
      end
      S_HOLD: begin
        if (idx == LAST_IDX) begin
          state_next = S_DONE;
        end else begin
          idx_next   = idx + IDX_W'(1);
          state_next = S_WAIT;
        end
      end
      S_DONE: begin
        io_done    = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (io_abort && (state != S_IDLE)) begin
      state_next = S_IDLE;
      idx_next   = '0;
      data_next  = data_q;
    end
  end

  assign io_d_out = data_q;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: per-scenario stimulus tables run against a
// transaction-level reference that walks loads word by word.
module tb_config_loader;

  localparam int NW   = 20;
  localparam int MAXC = 420;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_start;
  logic          io_abort;
  logic          io_word_valid;
  logic [31:0]   io_word_data;
  logic          io_word_ready;
  logic [31:0]   io_d_out;
  logic [NW-1:0] io_configs_en;
  logic          io_busy;
  logic          io_done;

  config_loader #(.WORD_W(32), .NUM_WORDS(NW), .IDX_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_abort      (io_abort),
    .io_word_valid (io_word_valid),
    .io_word_data  (io_word_data),
    .io_word_ready (io_word_ready),
    .io_d_out      (io_d_out),
    .io_configs_en (io_configs_en),
    .io_busy       (io_busy),
    .io_done       (io_done)
  );

  always #5 clk = ~clk;

  // stimulus per cycle
  bit            s_rst   [MAXC];
  bit            s_start [MAXC];
  bit            s_abort [MAXC];
  bit            s_valid [MAXC];
  logic [31:0]   s_data  [MAXC];
  // expected outputs per cycle
  bit            e_rdy   [MAXC];
  bit            e_bsy   [MAXC];
  bit            e_done  [MAXC];
  logic [NW-1:0] e_en    [MAXC];
  logic [31:0]   e_dout  [MAXC];
  // words of the load and latch array images
  logic [31:0]   wl      [NW];
  logic [31:0]   m_arr   [NW];
  logic [31:0]   mon_arr [NW];

  int n_checks = 0;
  int n_errors = 0;
  int scen     = 0;
  int cyc      = 0;
  int done_at  = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s scen=%0d cyc=%0d got=%h exp=%h", tag, scen, cyc, got, exp);
    end
  endtask

  task automatic clear_stim(input int n);
    for (int i = 0; i < n; i++) begin
      s_rst[i] = 1'b0; s_start[i] = 1'b0; s_abort[i] = 1'b0; s_valid[i] = 1'b1;
      s_data[i] = $urandom;
    end
    s_rst[0] = 1'b1;
    for (int k = 0; k < NW; k++) wl[k] = $urandom;
  endtask

  // Walk the stimulus as a sequence of loads: a load waits for each of the NW
  // words in turn, spends three cycles (setup, strobe, hold) per word, then one
  // done cycle. Abort or reset cut the load short; the word bus is set to the
  // word the load is waiting for during its ready cycles.
  task automatic build_model(input int n);
    int c, k;
    bit stop, got;
    logic [31:0] dcur;
    for (int i = 0; i < n; i++) begin
      e_rdy[i] = 1'b0; e_bsy[i] = 1'b0; e_done[i] = 1'b0; e_en[i] = '0; e_dout[i] = '0;
    end
    c = 0;
    dcur = '0;
    while (c < n) begin
      e_dout[c] = dcur;
      if (s_rst[c]) begin
        dcur = '0;
        c++;
      end else if (!s_start[c]) begin
        c++;
      end else begin
        c++;
        k = 0;
        stop = 1'b0;
        got = 1'b1;
        while (!stop && got && k < NW && c < n) begin
          got = 1'b0;
          while (!stop && !got && c < n) begin
            s_data[c] = wl[k];
            e_rdy[c] = 1'b1; e_bsy[c] = 1'b1; e_dout[c] = dcur;
            if (s_rst[c]) begin dcur = '0; stop = 1'b1; end
            else if (s_abort[c]) stop = 1'b1;
            else if (s_valid[c]) begin dcur = wl[k]; got = 1'b1; end
            c++;
          end
          for (int j = 0; j < 3 && got && !stop && c < n; j++) begin
            e_bsy[c] = 1'b1; e_dout[c] = dcur;
            if (j == 1) begin
              e_en[c] = NW'(1) << k;
              m_arr[k] = dcur;
            end
            if (s_rst[c]) begin dcur = '0; stop = 1'b1; end
            else if (s_abort[c]) stop = 1'b1;
            c++;
          end
          if (got && !stop) k++;
        end
        if (!stop && k == NW && c < n) begin
          e_bsy[c] = 1'b1; e_done[c] = 1'b1; e_dout[c] = dcur;
          if (s_rst[c]) dcur = '0;
          c++;
        end
      end
    end
  endtask

  task automatic run(input int n);
    logic [NW-1:0] en_prev;
    logic [31:0]   d_prev;
    bit            rst_prev;
    en_prev = '0;
    d_prev = '0;
    rst_prev = 1'b1;
    done_at = -1;
    for (int c = 0; c < n; c++) begin
      cyc = c;
      reset         = s_rst[c];
      io_start      = s_start[c];
      io_abort      = s_abort[c];
      io_word_valid = s_valid[c];
      io_word_data  = s_data[c];
      if (c > 0) begin
        check_eq("ready", 32'(io_word_ready), 32'(e_rdy[c]));
        check_eq("busy",  32'(io_busy),       32'(e_bsy[c]));
        check_eq("done",  32'(io_done),       32'(e_done[c]));
        check_eq("en",    32'(io_configs_en), 32'(e_en[c]));
        check_eq("dout",  io_d_out,           e_dout[c]);
        check_eq("onehot", 32'($onehot0(io_configs_en)), 32'd1);
        if (!rst_prev && (en_prev != '0 || io_configs_en != '0))
          check_eq("dstable", io_d_out, d_prev);
        for (int i = 0; i < NW; i++)
          if (io_configs_en[i]) mon_arr[i] = io_d_out;
        if (io_done && done_at < 0) done_at = c;
        en_prev = io_configs_en;
        d_prev = io_d_out;
        rst_prev = s_rst[c - 1] ? 1'b1 : 1'b0;
        if (c > 0 && s_rst[c - 1]) rst_prev = 1'b1; else rst_prev = 1'b0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_array();
    for (int k = 0; k < NW; k++) check_eq("array", mon_arr[k], m_arr[k]);
  endtask

  initial begin
    for (int k = 0; k < NW; k++) begin m_arr[k] = '0; mon_arr[k] = '0; end
    reset = 1'b1; io_start = 1'b0; io_abort = 1'b0; io_word_valid = 1'b0; io_word_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // 1: full load, words 0x1000_0000+k back to back; valid also high in IDLE
    scen = 1;
    clear_stim(90);
    for (int k = 0; k < NW; k++) wl[k] = 32'h1000_0000 + k;
    s_start[2] = 1'b1;
    build_model(90);
    run(90);
    // start cycle + 20 words * 4 cycles puts the done cycle 81 cycles after start
    check_eq("done_lat", 32'(done_at), 32'(2 + 81));
    check_array();

    // 2: valid withheld for 7 cycles before word 5
    scen = 2;
    clear_stim(100);
    s_start[2] = 1'b1;
    for (int c = 23; c < 30; c++) s_valid[c] = 1'b0;
    build_model(100);
    run(100);
    check_eq("done_lat", 32'(done_at), 32'(2 + 81 + 7));
    check_array();

    // 3: abort in strobe of word 9, then restart (abort with start in IDLE)
    scen = 3;
    clear_stim(135);
    s_start[2] = 1'b1;
    s_abort[41] = 1'b1;
    s_start[45] = 1'b1;
    s_abort[45] = 1'b1;
    build_model(135);
    run(135);
    check_eq("done_lat", 32'(done_at), 32'(45 + 81));
    check_array();

    // 4: reset in setup of word 3, words ignored until the next start
    scen = 4;
    clear_stim(120);
    s_start[2] = 1'b1;
    s_rst[16] = 1'b1;
    s_start[30] = 1'b1;
    build_model(120);
    run(120);
    check_eq("done_lat", 32'(done_at), 32'(30 + 81));
    check_array();

    // 5: start pulsed during word 4 has no effect
    scen = 5;
    clear_stim(90);
    s_start[2] = 1'b1;
    s_start[20] = 1'b1;
    build_model(90);
    run(90);
    check_eq("done_lat", 32'(done_at), 32'(2 + 81));
    check_array();

    // 6: abort in WAIT with valid high; the word is not captured
    scen = 6;
    clear_stim(95);
    s_start[2] = 1'b1;
    s_abort[3] = 1'b1;
    s_start[6] = 1'b1;
    build_model(95);
    run(95);
    check_eq("done_lat", 32'(done_at), 32'(6 + 81));
    check_array();

    // 7: random valid, start, abort and reset
    scen = 7;
    clear_stim(MAXC);
    for (int c = 1; c < MAXC; c++) begin
      s_valid[c] = ($urandom_range(0, 1) == 1);
      s_start[c] = ($urandom_range(0, 9) == 0);
      s_abort[c] = ($urandom_range(0, 59) == 0);
      s_rst[c]   = ($urandom_range(0, 149) == 0);
    end
    build_model(MAXC);
    run(MAXC);
    check_array();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
